// File: rtl/horn_pkg.sv
// Shared types and constants for the horn tone-path controller.
package horn_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FAULT    = 3'd1,
        MANUAL   = 3'd2,
        WARN_ON  = 3'd3,
        WARN_OFF = 3'd4
    } horn_state_t;

    typedef struct packed {
        logic fault;
        logic button;
        logic warn;
    } horn_req_t;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_WARN   = 2'd1;
    localparam logic [1:0] MODE_MANUAL = 2'd2;
    localparam logic [1:0] MODE_FAULT  = 2'd3;

    localparam logic [7:0] STEP_HI_DEF  = 8'd4;
    localparam logic [7:0] STEP_LO_DEF  = 8'd2;
    localparam logic [7:0] STEP_MID_DEF = 8'd3;
    localparam logic [7:0] AMP_FULL     = 8'hFF;

    localparam int DWELL_W = 16;

    function automatic logic [1:0] mode_of(input horn_state_t s);
        case (s)
            FAULT:            return MODE_FAULT;
            MANUAL:           return MODE_MANUAL;
            WARN_ON, WARN_OFF: return MODE_WARN;
            default:          return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/horn_tick_gen.sv
// Free-running millisecond prescaler: one-cycle tick_o when the count reaches TICK_DIV-1.
module horn_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int               CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/horn_sequencer.sv
// Horn request arbiter and cadence FSM driving the tone generator.
// Optional amplitude soft-start ramp is enabled by defining HORN_SOFTSTART_EN.
module horn_sequencer
    import horn_pkg::*;
#(
    parameter int         TICK_DIV    = 50000,
    parameter int         MIN_ON_MS   = 500,
    parameter int         WARN_ON_MS  = 200,
    parameter int         WARN_OFF_MS = 800,
    parameter int         WARBLE_MS   = 250,
    parameter logic [7:0] STEP_HI     = STEP_HI_DEF,
    parameter logic [7:0] STEP_LO     = STEP_LO_DEF,
    parameter logic [7:0] STEP_MID    = STEP_MID_DEF
) (
    input  logic       c50M,
    input  logic       nReset,
    input  logic       FaultReq,
    input  logic       Button,
    input  logic       WarnReq,
    output logic       ToneEn,
    output logic [7:0] ToneStep,
    output logic [7:0] Amplitude,
    output logic [1:0] Mode,
    output logic       Busy
);

    localparam logic [DWELL_W-1:0] MIN_ON    = DWELL_W'(MIN_ON_MS);
    localparam logic [DWELL_W-1:0] WARN_ON_T = DWELL_W'(WARN_ON_MS);
    localparam logic [DWELL_W-1:0] WARN_OFF_T = DWELL_W'(WARN_OFF_MS);
    localparam logic [DWELL_W-1:0] WARBLE_T  = DWELL_W'(WARBLE_MS - 1);

    logic tick;

    horn_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (c50M),
        .rst_ni (nReset),
        .tick_o (tick)
    );

    horn_req_t          sync1_q, sync2_q;
    horn_state_t        state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] warble_cnt_q, warble_cnt_d;
    logic               warble_lo_q, warble_lo_d;
    logic               tone_en_q, tone_en_d;
    logic [7:0]         step_q, step_d;
    logic [7:0]         amp_q, amp_d;
    logic [1:0]         mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               entering;

    always_ff @(posedge c50M) begin
        if (!nReset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= IDLE;
            dwell_q      <= '0;
            warble_cnt_q <= '0;
            warble_lo_q  <= 1'b0;
            tone_en_q    <= 1'b0;
            step_q       <= '0;
            amp_q        <= '0;
            mode_q       <= MODE_IDLE;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= '{fault: FaultReq, button: Button, warn: WarnReq};
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            warble_cnt_q <= warble_cnt_d;
            warble_lo_q  <= warble_lo_d;
            tone_en_q    <= tone_en_d;
            step_q       <= step_d;
            amp_q        <= amp_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sync2_q.fault)       state_d = FAULT;
                else if (sync2_q.button) state_d = MANUAL;
                else if (sync2_q.warn)   state_d = WARN_ON;
            end
            FAULT: begin
                if (!sync2_q.fault) begin
                    if (sync2_q.button)    state_d = MANUAL;
                    else if (sync2_q.warn) state_d = WARN_ON;
                    else                   state_d = IDLE;
                end
            end
            MANUAL: begin
                if (sync2_q.fault)                          state_d = FAULT;
                else if (!sync2_q.button && dwell_q >= MIN_ON) state_d = sync2_q.warn ? WARN_ON : IDLE;
            end
            WARN_ON: begin
                if (sync2_q.fault)            state_d = FAULT;
                else if (sync2_q.button)      state_d = MANUAL;
                else if (!sync2_q.warn)       state_d = IDLE;
                else if (dwell_q >= WARN_ON_T) state_d = WARN_OFF;
            end
            WARN_OFF: begin
                if (sync2_q.fault)             state_d = FAULT;
                else if (sync2_q.button)       state_d = MANUAL;
                else if (!sync2_q.warn)        state_d = IDLE;
                else if (dwell_q >= WARN_OFF_T) state_d = WARN_ON;
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry clear beats a coincident tick, so each state's dwell starts from zero.
    always_comb begin
        entering     = (state_d != state_q);
        dwell_d      = dwell_q;
        warble_cnt_d = warble_cnt_q;
        warble_lo_d  = warble_lo_q;
        if (entering) begin
            dwell_d      = '0;
            warble_cnt_d = '0;
            warble_lo_d  = 1'b0;
        end else if (tick) begin
            if (dwell_q != '1) dwell_d = dwell_q + 1'b1;
            if (state_q == FAULT) begin
                if (warble_cnt_q >= WARBLE_T) begin
                    warble_cnt_d = '0;
                    warble_lo_d  = ~warble_lo_q;
                end else begin
                    warble_cnt_d = warble_cnt_q + 1'b1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        tone_en_d = (state_d inside {FAULT, MANUAL, WARN_ON});
        mode_d    = mode_of(state_d);
        busy_d    = (state_d != IDLE);
        case (state_d)
            FAULT:   step_d = warble_lo_d ? STEP_LO : STEP_HI;
            MANUAL:  step_d = STEP_MID;
            WARN_ON: step_d = STEP_LO;
            default: step_d = '0;
        endcase
`ifdef HORN_SOFTSTART_EN
        if (!tone_en_d || !tone_en_q)      amp_d = '0;
        else if (tick && amp_q != AMP_FULL) amp_d = amp_q + 1'b1;
        else                               amp_d = amp_q;
`else
        amp_d = tone_en_d ? AMP_FULL : '0;
`endif
    end

    assign ToneEn    = tone_en_q;
    assign ToneStep  = step_q;
    assign Amplitude = amp_q;
    assign Mode      = mode_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_horn_sequencer.sv
// Directed bench for horn_sequencer with short timing (TICK_DIV=4, 1 ms tick = 4 clocks).
module tb_horn_sequencer;

    logic       c50M     = 1'b0;
    logic       nReset   = 1'b0;
    logic       FaultReq = 1'b0;
    logic       Button   = 1'b0;
    logic       WarnReq  = 1'b0;
    logic       ToneEn;
    logic [7:0] ToneStep;
    logic [7:0] Amplitude;
    logic [1:0] Mode;
    logic       Busy;

    int cyc;
    int n_checks = 0;
    int n_errors = 0;
    int len;

`ifdef HORN_SOFTSTART_EN
    localparam int AMP_ENTRY = 0;
`else
    localparam int AMP_ENTRY = 255;
`endif

    horn_sequencer #(
        .TICK_DIV    (4),
        .MIN_ON_MS   (5),
        .WARN_ON_MS  (2),
        .WARN_OFF_MS (3),
        .WARBLE_MS   (2),
        .STEP_HI     (8'd4),
        .STEP_LO     (8'd2),
        .STEP_MID    (8'd3)
    ) dut (
        .c50M      (c50M),
        .nReset    (nReset),
        .FaultReq  (FaultReq),
        .Button    (Button),
        .WarnReq   (WarnReq),
        .ToneEn    (ToneEn),
        .ToneStep  (ToneStep),
        .Amplitude (Amplitude),
        .Mode      (Mode),
        .Busy      (Busy)
    );

    always #5 c50M = ~c50M;

    // Edge count since reset release; the DUT's tick is sampled on edges where cyc % 4 == 0.
    always @(posedge c50M) begin
        if (!nReset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge c50M);
            #1;
        end
    endtask

    task automatic to_phase(input int p);
        do begin
            @(posedge c50M);
            #1;
        end while (cyc % 4 != p);
    endtask

    function automatic int probe(input int sel);
        case (sel)
            0:       return int'(Mode);
            1:       return int'(ToneEn);
            default: return int'(ToneStep);
        endcase
    endfunction

    // Called at a negedge: waits for the value to appear, then counts consecutive cycles it holds.
    task automatic run_len(input int sel, input int v, output int n);
        int guard;
        guard = 0;
        n = 0;
        while (probe(sel) != v && guard < 100) begin
            @(negedge c50M);
            guard++;
        end
        if (probe(sel) != v) begin
            n = -1;
            return;
        end
        while (probe(sel) == v && n < 100) begin
            n++;
            @(negedge c50M);
        end
    endtask

    initial begin
        repeat (3) @(posedge c50M);
        #1 nReset = 1'b1;
        @(negedge c50M);
        check("rst_en", ToneEn, 0);
        check("rst_mode", Mode, 0);
        check("rst_busy", Busy, 0);
        check("rst_amp", Amplitude, 0);
        check("rst_step", ToneStep, 0);

        // One-cycle button pulse: MANUAL entered 3 edges later, held for the 5 ms minimum.
        to_phase(2);
        Button = 1'b1;
        step_cycles(1);
        Button = 1'b0;
        @(negedge c50M);
        check("btn_lat1", Mode, 0);
        @(negedge c50M);
        check("btn_lat2", Mode, 0);
        @(negedge c50M);
        check("btn_mode", Mode, 2);
        check("btn_step", ToneStep, 3);
        check("btn_en", ToneEn, 1);
        check("btn_amp", Amplitude, AMP_ENTRY);
        check("btn_busy", Busy, 1);
        run_len(0, 2, len);
        check("btn_min_on_len", len, 20);
        check("btn_idle_busy", Busy, 0);
        check("btn_idle_en", ToneEn, 0);

        // Held warning: 2 ms on / 3 ms off, then drop during WARN_OFF.
        to_phase(2);
        WarnReq = 1'b1;
        step_cycles(3);
        @(negedge c50M);
        check("warn_mode", Mode, 1);
        check("warn_step", ToneStep, 2);
        check("warn_en", ToneEn, 1);
        run_len(1, 1, len);
        check("warn_on_len1", len, 8);
        check("warn_off_mode", Mode, 1);
        check("warn_off_busy", Busy, 1);
        check("warn_off_step", ToneStep, 0);
        check("warn_off_amp", Amplitude, 0);
        run_len(1, 0, len);
        check("warn_off_len", len, 12);
        run_len(1, 1, len);
        check("warn_on_len2", len, 8);
        step_cycles(1);
        WarnReq = 1'b0;
        repeat (3) @(negedge c50M);
        check("warn_drop_busy", Busy, 1);
        @(negedge c50M);
        check("warn_drop_idle", Busy, 0);
        check("warn_drop_mode", Mode, 0);

        // Fault while MANUAL has dwell=1: warble 4/2, then release to IDLE.
        to_phase(2);
        Button = 1'b1;
        step_cycles(1);
        Button = 1'b0;
        step_cycles(4);
        FaultReq = 1'b1;
        @(negedge c50M);
        check("flt_pre_mode", Mode, 2);
        run_len(2, 4, len);
        check("flt_hi_len1", len, 6);
        check("flt_mode", Mode, 3);
        run_len(2, 2, len);
        check("flt_lo_len", len, 8);
        run_len(2, 4, len);
        check("flt_hi_len2", len, 8);
        check("flt_lo_again", ToneStep, 2);
        step_cycles(1);
        FaultReq = 1'b0;
        repeat (3) @(negedge c50M);
        check("flt_hold_mode", Mode, 3);
        @(negedge c50M);
        check("flt_rel_mode", Mode, 0);
        check("flt_rel_en", ToneEn, 0);

        // All requests together: fault wins, then manual, then warn.
        to_phase(2);
        FaultReq = 1'b1;
        Button   = 1'b1;
        WarnReq  = 1'b1;
        step_cycles(3);
        @(negedge c50M);
        check("all_fault_mode", Mode, 3);
        check("all_fault_step", ToneStep, 4);
        step_cycles(1);
        FaultReq = 1'b0;
        step_cycles(3);
        @(negedge c50M);
        check("all_manual_mode", Mode, 2);
        check("all_manual_step", ToneStep, 3);
        step_cycles(30);
        Button = 1'b0;
        repeat (3) @(negedge c50M);
        check("all_manual_hold", Mode, 2);
        @(negedge c50M);
        check("all_warn_mode", Mode, 1);
        check("all_warn_step", ToneStep, 2);
        step_cycles(1);
        WarnReq = 1'b0;
        repeat (4) @(negedge c50M);
        check("all_idle_busy", Busy, 0);

        // Reset asserted mid-FAULT silences the horn at that edge.
        FaultReq = 1'b1;
        step_cycles(3);
        @(negedge c50M);
        check("rst_pre_mode", Mode, 3);
        nReset = 1'b0;
        @(negedge c50M);
        check("rst_mid_en", ToneEn, 0);
        check("rst_mid_mode", Mode, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_amp", Amplitude, 0);
        nReset   = 1'b1;
        FaultReq = 1'b0;
        repeat (4) @(negedge c50M);
        check("rst_after_busy", Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
